// File: rtl/apb_mem_slave.sv
// APB3/APB4 memory-mapped slave: word-organised RAM with byte strobes, configurable
// wait states and PSLVERR on unaligned or out-of-range addresses. All outputs registered.
module apb_mem_slave #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [ADDR_W-1:0]   paddr_i,
  input  logic [DATA_W-1:0]   pwdata_i,
  input  logic [DATA_W/8-1:0] pstrb_i,
  output logic [DATA_W-1:0]   prdata_o,
  output logic                pready_o,
  output logic                pslverr_o
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned Lb       = $clog2(NumBytes);
  localparam int unsigned IdxW     = ADDR_W - Lb;
  localparam int unsigned MemAw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [IdxW-1:0]     word_idx;
  logic [31:0]         idx_ext;
  logic [MemAw-1:0]    mem_addr;
  logic                unaligned;
  logic                out_of_range;
  logic                addr_err;
  logic                access;
  logic                resp_go;
  logic                mem_we;

  // Address decode
  assign word_idx     = paddr_i[ADDR_W-1:Lb];
  assign idx_ext      = 32'(word_idx);
  assign mem_addr     = word_idx[MemAw-1:0];
  assign out_of_range = (idx_ext >= DEPTH);

  if (Lb > 0) begin : g_align
    assign unaligned = |paddr_i[Lb-1:0];
  end else begin : g_no_align
    assign unaligned = 1'b0;
  end

  assign addr_err = unaligned | out_of_range;
  assign access   = psel_i & penable_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    resp_go   = 1'b0;
    mem_we    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (WAIT_CYC == 0) begin
            resp_go = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYC - 1);
          end
        end
      end
      StWait: begin
        if (!access) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          resp_go = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Side effects happen on the edge that enters StResp, using the bus values of that edge
    if (resp_go) begin
      state_d   = StResp;
      pready_d  = 1'b1;
      pslverr_d = addr_err;
      if (pwrite_i) begin
        mem_we = ~addr_err & preset;
      end else begin
        prdata_d = addr_err ? '0 : mem_q[mem_addr];
      end
    end
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // RAM contents are deliberately not reset
  always_ff @(posedge pclk) begin
    if (mem_we) begin
      for (int k = 0; k < NumBytes; k++) begin
        if (pstrb_i[k]) begin
          mem_q[mem_addr][8*k +: 8] <= pwdata_i[8*k +: 8];
        end
      end
    end
  end

  assign prdata_o  = prdata_q;
  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave: a WAIT_CYC=2 instance and a WAIT_CYC=0 instance
// share one APB bus (separate psel); expected responses come from a queue fed by a RAM model.
module tb_apb_mem_slave;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel2, psel0, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata2, prdata0;
  logic        pready2, pready0, pslverr2, pslverr0;

  always #5 pclk = ~pclk;

  apb_mem_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_CYC(2)) dut (
    .pclk(pclk), .preset(preset), .psel_i(psel2), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata2), .pready_o(pready2), .pslverr_o(pslverr2)
  );

  apb_mem_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_CYC(0)) dut0 (
    .pclk(pclk), .preset(preset), .psel_i(psel0), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata0), .pready_o(pready0), .pslverr_o(pslverr0)
  );

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } op_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  logic [31:0] mdl [2][256];
  logic [31:0] last_rd [2];
  logic        use0;

  logic [31:0] obs_data;
  logic        obs_err;
  int          obs_lat;
  logic        obs_to;

  logic [31:0] prdata_m;
  logic        pready_m, pslverr_m;
  assign prdata_m  = use0 ? prdata0  : prdata2;
  assign pready_m  = use0 ? pready0  : pready2;
  assign pslverr_m = use0 ? pslverr0 : pslverr2;

  // Model: computes the expected response of an op and pushes it to the scoreboard
  task automatic predict(input op_t op);
    exp_t      e;
    int        sel;
    int        idx;
    logic      err;
    sel = use0 ? 0 : 1;
    idx = int'(op.addr[11:2]);
    err = (op.addr[1:0] != 2'b00) || (idx >= 256);
    e.err = err;
    e.lat = use0 ? 1 : 3;
    if (op.we) begin
      if (!err) begin
        for (int k = 0; k < 4; k++) begin
          if (op.strb[k]) mdl[sel][idx][8*k +: 8] = op.data[8*k +: 8];
        end
      end
      e.data = last_rd[sel];
    end else begin
      e.data = err ? 32'h0 : mdl[sel][idx];
      last_rd[sel] = e.data;
    end
    exp_q.push_back(e);
  endtask

  task automatic xfer(input op_t op);
    @(posedge pclk); #1;
    if (use0) psel0 = 1'b1; else psel2 = 1'b1;
    penable = 1'b0;
    pwrite  = op.we;
    paddr   = op.addr;
    pwdata  = op.data;
    pstrb   = op.strb;
    @(posedge pclk); #1;
    penable = 1'b1;
    obs_lat = 0;
    obs_to  = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge pclk); #1;
      if (pready_m) begin
        obs_lat  = i;
        obs_to   = 1'b0;
        obs_data = prdata_m;
        obs_err  = pslverr_m;
        break;
      end
    end
    psel0   = 1'b0;
    psel2   = 1'b0;
    penable = 1'b0;
  endtask

  task automatic run_ops(input string name, input op_t ops[$]);
    exp_t e;
    foreach (ops[i]) begin
      predict(ops[i]);
      xfer(ops[i]);
      e = exp_q.pop_front();
      n_tests++;
      if (obs_to || obs_data !== e.data || obs_err !== e.err || obs_lat != e.lat) begin
        n_fail++;
        $display("FAIL %s[%0d] addr=%h we=%0b: got data=%h err=%b lat=%0d timeout=%0b, want data=%h err=%b lat=%0d",
                 name, i, ops[i].addr, ops[i].we, obs_data, obs_err, obs_lat, obs_to,
                 e.data, e.err, e.lat);
      end
    end
  endtask

  task automatic test_reset();
    preset = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    n_tests++;
    if ({pready2, pslverr2, prdata2} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_w2: got rdy=%b err=%b data=%h, want 0 0 0", pready2, pslverr2, prdata2);
    end
    n_tests++;
    if ({pready0, pslverr0, prdata0} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_w0: got rdy=%b err=%b data=%h, want 0 0 0", pready0, pslverr0, prdata0);
    end
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    n_tests++;
    if ({pready2, pslverr2, pready0, pslverr0} !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_idle: got rdy2=%b err2=%b rdy0=%b err0=%b, want all 0",
               pready2, pslverr2, pready0, pslverr0);
    end
  endtask

  task automatic test_write_read();
    op_t ops[$];
    use0 = 1'b0;
    ops.push_back('{1'b1, 12'h010, 32'h0A0B0C0D, 4'hF});
    ops.push_back('{1'b0, 12'h010, 32'h0,        4'h0});
    ops.push_back('{1'b1, 12'h000, 32'hCAFEF00D, 4'hF});
    ops.push_back('{1'b1, 12'h3FC, 32'h5A5A5A5A, 4'hF});
    ops.push_back('{1'b0, 12'h000, 32'h0,        4'hF});
    ops.push_back('{1'b0, 12'h3FC, 32'h0,        4'h0});
    run_ops("write_read", ops);
  endtask

  task automatic test_strobe();
    op_t ops[$];
    use0 = 1'b0;
    ops.push_back('{1'b1, 12'h020, 32'h11223344, 4'hF});
    ops.push_back('{1'b1, 12'h020, 32'hFFFFFFFF, 4'h5});
    ops.push_back('{1'b0, 12'h020, 32'h0,        4'h0});
    run_ops("strobe", ops);
    n_tests++;
    if (obs_data !== 32'h11FF33FF) begin
      n_fail++;
      $display("FAIL strobe_const: got %h, want 11ff33ff", obs_data);
    end
    ops.delete();
    ops.push_back('{1'b1, 12'h020, 32'h00000000, 4'h0});
    ops.push_back('{1'b1, 12'h020, 32'hA5A5A5A5, 4'hA});
    ops.push_back('{1'b0, 12'h020, 32'h0,        4'h0});
    run_ops("strobe_zero", ops);
  endtask

  task automatic test_errors();
    op_t ops[$];
    use0 = 1'b0;
    ops.push_back('{1'b0, 12'h400, 32'h0,        4'h0});
    ops.push_back('{1'b0, 12'h010, 32'h0,        4'h0});
    ops.push_back('{1'b0, 12'h013, 32'h0,        4'h0});
    ops.push_back('{1'b1, 12'h400, 32'hDEADBEEF, 4'hF});
    ops.push_back('{1'b1, 12'h012, 32'hDEADBEEF, 4'hF});
    ops.push_back('{1'b0, 12'h000, 32'h0,        4'h0});
    ops.push_back('{1'b0, 12'h3FC, 32'h0,        4'h0});
    ops.push_back('{1'b0, 12'h010, 32'h0,        4'h0});
    ops.push_back('{1'b0, 12'h020, 32'h0,        4'h0});
    run_ops("errors", ops);
  endtask

  task automatic test_abort();
    op_t ops[$];
    int  hits;
    use0 = 1'b0;
    ops.push_back('{1'b1, 12'h030, 32'h13579BDF, 4'hF});
    run_ops("abort_pre", ops);
    @(posedge pclk); #1;
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 12'h030; pwdata = 32'h24680ACE; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel2 = 1'b0; penable = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge pclk); #1;
      if (pready2 !== 1'b0) hits++;
    end
    n_tests++;
    if (hits != 0) begin
      n_fail++;
      $display("FAIL abort_no_pready: got %0d pready cycles, want 0", hits);
    end
    ops.delete();
    ops.push_back('{1'b0, 12'h030, 32'h0, 4'h0});
    run_ops("abort_post", ops);
  endtask

  task automatic test_reset_mid();
    op_t ops[$];
    use0 = 1'b0;
    ops.push_back('{1'b1, 12'h040, 32'h600DF00D, 4'hF});
    ops.push_back('{1'b0, 12'h040, 32'h0,        4'h0});
    run_ops("rst_mid_pre", ops);
    @(posedge pclk); #1;
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 12'h040; pwdata = 32'hBAD0BAD0; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    #1;
    n_tests++;
    if ({pready2, pslverr2, prdata2} !== 34'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got rdy=%b err=%b data=%h, want 0 0 0",
               pready2, pslverr2, prdata2);
    end
    repeat (3) @(posedge pclk);
    #1;
    psel2 = 1'b0; penable = 1'b0;
    preset = 1'b1;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    ops.delete();
    ops.push_back('{1'b1, 12'h050, 32'h01020304, 4'hF});
    ops.push_back('{1'b0, 12'h040, 32'h0,        4'h0});
    run_ops("rst_mid_post", ops);
  endtask

  task automatic test_back_to_back();
    op_t ops[$];
    use0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ops.push_back('{1'b1, 12'(16 * i + 4), 32'hC0DE0000 + 32'(i * 17), 4'hF});
    end
    for (int i = 3; i >= 0; i--) begin
      ops.push_back('{1'b0, 12'(16 * i + 4), 32'h0, 4'h0});
    end
    ops.push_back('{1'b0, 12'h401, 32'h0, 4'h0});
    run_ops("b2b_w0", ops);
    use0 = 1'b0;
  endtask

  initial begin
    preset = 1'b1; psel2 = 1'b0; psel0 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; use0 = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    #2;
    test_reset();
    test_write_read();
    test_strobe();
    test_errors();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
